core_muldiv: RTL and testbench
==============================

# core_muldiv

Iterative multiply/divide sequencer attached to the EX stage of the 64-bit MIPS pipeline. It accepts one MULT/MULTU/DIV/DIVU request, runs a fixed-latency shift-add multiply or restoring divide, and commits the result to the architectural HI/LO registers. While the unit is busy it raises `stall` so EX holds any instruction that touches HI/LO or issues a new request. `flush` aborts an in-flight operation without side effects.

## Interface
- WIDTH, 64, operand/HI/LO width; iteration count = WIDTH
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; reset reset, asynchronous, active-high; clock clock
- start  in  1  request valid; sampled only in IDLE
- op  in  muldiv_op_t (2)  MULT, MULTU, DIV, DIVU
- a  in  WIDTH  multiplicand / dividend (forwarded EX operand A)
- b  in  WIDTH  multiplier / divisor (forwarded EX operand B)
- hilo_read  in  1  EX instruction reads HI or LO (MFHI/MFLO)
- hi_we, lo_we  in  1 each  MTHI/MTLO write enables
- wdata  in  WIDTH  MTHI/MTLO data
- flush  in  1  abort in-flight operation
- busy  out  1  state != IDLE
- stall  out  1  busy & (start | hilo_read | hi_we | lo_we); combinational
- done  out  1  one-cycle registered pulse after HI/LO commit
- hi, lo  out  WIDTH each  architectural HI/LO registers

## Operation
- States: IDLE, RUN, FIX. Reset: IDLE, hi=lo=0, done=0, counter=0.
- IDLE & start: latch op, |a|, |b| (signed ops take magnitudes; unsigned pass through), record result signs; counter=0; -> RUN.
- RUN: one radix-2 step per cycle; counter increments; after step WIDTH-1 -> FIX.
  - Multiply: 2*WIDTH-bit accumulator, add-if-LSB then shift right.
  - Divide: restoring; shift remainder left, trial subtract, quotient bit = no-borrow.
- FIX: apply signs, write hi/lo, -> IDLE, set done for the next cycle.
  - MULT: 2*WIDTH product negated if sign(a)!=sign(b); hi=upper, lo=lower.
  - DIV: quotient negated if signs differ; remainder takes sign of a.
  - Divisor 0 (any divide): lo=all-ones, hi=a (original, unsigned value); same latency.
  - DIV of -2^(WIDTH-1) by -1: lo=-2^(WIDTH-1) (wrap), hi=0.
- MTHI/MTLO in IDLE: hi/lo <= wdata at the edge. When busy: ignored and stall asserted.
- IDLE with start and hi_we/lo_we in the same cycle: start wins, the write is dropped.
- start while busy: ignored; stall holds EX until IDLE.
- flush in RUN or FIX: -> IDLE at the next edge, hi/lo unchanged, no done pulse. flush in IDLE blocks a same-cycle start.
- Reset mid-operation: immediate IDLE, hi=lo=0.

## Timing
- Start accepted at edge E0; RUN spans edges E1..E64 (WIDTH=64); FIX commits hi/lo at E65; done high in the cycle after E65.
- Total latency is WIDTH+1 edges for every op and every operand value.
- busy rises in the cycle after E0 and falls in the cycle after E65.
- A new start is accepted in the same cycle done is high.
- stall is combinational from busy and inputs; no other output depends on inputs combinationally.

## Structure
- The `structures` package holds `muldiv_op_t` (2-bit enum MULT=0, MULTU=1, DIV=2, DIVU=3) and `MULDIV_STATE_t`.
- Sub-module `muldiv_step` is combinational: one multiply or divide iteration over (acc, divisor, op class). The controller keeps state, counter, sign flags and HI/LO.

## Test plan
- MULTU a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> after 65 edges hi=1, lo=0xFFFF_FFFF_FFFF_FFFE, one done pulse.
- MULT a=-3, b=5 -> hi=all-ones, lo=-15. DIV a=-7, b=2 -> lo=-3, hi=-1.
- DIVU a=100, b=0 -> lo=all-ones, hi=100. DIV a=0x8000_0000_0000_0000, b=-1 -> lo=0x8000_0000_0000_0000, hi=0.
- Busy cycle 10 with hilo_read=1 and hi_we=1, wdata=5 -> stall=1, hi unchanged; after done, MTHI writes 5.
- flush at RUN cycle 30 -> IDLE next edge, hi/lo keep prior values, no done. Reset at RUN cycle 20 -> hi=lo=0, busy=0.
- Back-to-back: second start in the done cycle -> accepted with no bubble; results of both ops correct.

Source files
------------

// File: rtl/structures.sv
// Shared types for the EX-stage multiply/divide sequencer.
// Holds the op encoding, FSM states and default datapath width.
package structures;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } MULDIV_STATE_t;

endpackage

// File: rtl/core_muldiv_if.sv
// EX <-> muldiv bundle: request, HI/LO access, status and HI/LO.
// master = EX pipeline side, slave = the muldiv unit.
interface core_muldiv_if
  import structures::*;
#(
  parameter int WIDTH = XLEN
);
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_read;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    output hilo_read, hi_we, lo_we,
    output wdata, flush,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    input  hilo_read, hi_we, lo_we,
    input  wdata, flush,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// acc_i/acc_o: {hi half, lo half}; opnd_i: multiplicand/divisor.
module muldiv_step #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum   = '0;
    trial = '0;
    acc_o = acc_i;
    if (div_i) begin
      // {rem, next dividend bit} minus divisor; msb is the borrow
      trial = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
      if (!trial[WIDTH])
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      else
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
    end else begin
      sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
      if (acc_i[0])
        sum = sum + {1'b0, opnd_i};
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/core_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Ports: clock, reset (async high), md_if (core_muldiv_if.slave).
module core_muldiv
  import structures::*;
#(
  parameter int WIDTH = XLEN
) (
  input logic            clock,
  input logic            reset,
  core_muldiv_if.slave   md_if
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  MULDIV_STATE_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               go;
  logic               sgn;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // flush in IDLE suppresses a same-cycle request
  assign go    = (state_q == IDLE)
               & md_if.start & ~md_if.flush;
  assign sgn   = ~md_if.op[0];
  assign a_neg = sgn & md_if.a[WIDTH-1];
  assign b_neg = sgn & md_if.b[WIDTH-1];
  assign a_mag = a_neg ? -md_if.a : md_if.a;
  assign b_mag = b_neg ? -md_if.b : md_if.b;

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[WIDTH-1:0]
                      : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                       : acc_q[2*WIDTH-1:WIDTH];

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (div_q),
    .acc_o  (acc_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN: begin
        if (md_if.flush)
          state_d = IDLE;
        else if (cnt_q == LAST)
          state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    md_if.busy  = (state_q != IDLE);
    md_if.stall = md_if.busy
                & (md_if.start | md_if.hilo_read
                 | md_if.hi_we | md_if.lo_we);
    md_if.done  = done_q;
    md_if.hi    = hi_q;
    md_if.lo    = lo_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    a_d    = a_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          cnt_d  = '0;
          div_d  = md_if.op[1];
          a_d    = md_if.a;
          dz_d   = (md_if.b == '0);
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (md_if.op[1]) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
        end else begin
          if (md_if.hi_we) hi_d = md_if.wdata;
          if (md_if.lo_we) lo_d = md_if.wdata;
        end
      end
      RUN: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
      end
      FIX: begin
        if (!md_if.flush) begin
          done_d = 1'b1;
          if (!div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      acc_q  <= '0;
      opnd_q <= '0;
      a_q    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      a_q    <= a_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_core_muldiv.sv
// Directed bench for core_muldiv: vector table plus
// hand-written stall, flush, reset and back-to-back sequences.
module tb_core_muldiv
  import structures::*;
;
  localparam logic [63:0] ONES = '1;

  typedef struct {
    string       name;
    muldiv_op_t  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] hi;
    logic [63:0] lo;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   n;
  int   seen;
  vec_t vecs[10];

  core_muldiv_if #(.WIDTH(64)) bus ();

  core_muldiv #(.WIDTH(64)) dut (
    .clock (clock),
    .reset (reset),
    .md_if (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input muldiv_op_t op,
                        input logic [63:0] a,
                        input logic [63:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 200) begin
      @(posedge clock); #1;
      cnt++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{"multu_max", MULTU, ONES, 64'd2,
                64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[1] = '{"mult_m3x5", MULT,
                64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
                ONES, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2] = '{"div_m7d2", DIV,
                64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                ONES, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3] = '{"divu_by0", DIVU, 64'd100, 64'd0,
                64'd100, ONES};
    vecs[4] = '{"div_ovf", DIV,
                64'h8000_0000_0000_0000, ONES,
                64'd0, 64'h8000_0000_0000_0000};
    vecs[5] = '{"div_7dm2", DIV, 64'd7,
                64'hFFFF_FFFF_FFFF_FFFE,
                64'd1, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[6] = '{"mult_m1m1", MULT, ONES, ONES,
                64'd0, 64'd1};
    vecs[7] = '{"divu_100d7", DIVU, 64'd100, 64'd7,
                64'd2, 64'd14};
    vecs[8] = '{"div_m5by0", DIV,
                64'hFFFF_FFFF_FFFF_FFFB, 64'd0,
                64'hFFFF_FFFF_FFFF_FFFB, ONES};
    vecs[9] = '{"multu_2p64", MULTU,
                64'h1_0000_0000, 64'h1_0000_0000,
                64'd1, 64'd0};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = MULT;
    bus.a         = '0;
    bus.b         = '0;
    bus.hilo_read = 1'b0;
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b0;
    bus.wdata     = '0;
    bus.flush     = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", bus.hi, 64'd0);
    chk("rst_lo", bus.lo, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_busy"},
          64'(bus.busy), 64'd1);
      wait_done(n);
      chk({vecs[i].name, "_lat"}, 64'(n), 64'd65);
      chk({vecs[i].name, "_hi"}, bus.hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, bus.lo, vecs[i].lo);
      @(posedge clock); #1;
      chk({vecs[i].name, "_pulse"},
          64'(bus.done), 64'd0);
      chk({vecs[i].name, "_idle"},
          64'(bus.busy), 64'd0);
    end

    // HI/LO access while busy stalls and is dropped
    run_op(MULTU, 64'd3, 64'd4);
    repeat (10) begin
      @(posedge clock); #1;
    end
    bus.hilo_read = 1'b1;
    bus.hi_we     = 1'b1;
    bus.wdata     = 64'd5;
    #1;
    chk("stall_on", 64'(bus.stall), 64'd1);
    @(posedge clock); #1;
    chk("stall_hi_keep", bus.hi, 64'd1);
    bus.hilo_read = 1'b0;
    bus.hi_we     = 1'b0;
    #1;
    chk("stall_off", 64'(bus.stall), 64'd0);
    wait_done(n);
    chk("stall_lat", 64'(n), 64'd54);
    chk("stall_hi", bus.hi, 64'd0);
    chk("stall_lo", bus.lo, 64'd12);
    bus.hi_we = 1'b1;
    #1;
    chk("mthi_nostall", 64'(bus.stall), 64'd0);
    @(posedge clock); #1;
    bus.hi_we = 1'b0;
    chk("mthi_hi", bus.hi, 64'd5);
    chk("mthi_lo", bus.lo, 64'd12);

    // flush mid-RUN aborts without commit or done
    run_op(DIVU, 64'd100, 64'd3);
    repeat (30) begin
      @(posedge clock); #1;
    end
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("flush_nodone", 64'(seen), 64'd0);
    chk("flush_hi", bus.hi, 64'd5);
    chk("flush_lo", bus.lo, 64'd12);

    // flush in IDLE blocks start
    bus.flush = 1'b1;
    run_op(MULTU, 64'd1, 64'd1);
    bus.flush = 1'b0;
    chk("iflush_busy", 64'(bus.busy), 64'd0);

    // start beats a same-cycle MTHI
    bus.hi_we = 1'b1;
    bus.wdata = 64'd9;
    run_op(MULTU, 64'd6, 64'd7);
    bus.hi_we = 1'b0;
    chk("startwin_hi", bus.hi, 64'd5);
    wait_done(n);
    chk("startwin_lat", 64'(n), 64'd65);
    chk("startwin_lo", bus.lo, 64'd42);
    chk("startwin_hi2", bus.hi, 64'd0);

    // back-to-back starts in the done cycle
    run_op(MULT, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    chk("b2b1_busy", 64'(bus.busy), 64'd1);
    wait_done(n);
    chk("b2b1_lat", 64'(n), 64'd65);
    chk("b2b1_hi", bus.hi, ONES);
    chk("b2b1_lo", bus.lo, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(DIVU, 64'd100, 64'd7);
    chk("b2b2_busy", 64'(bus.busy), 64'd1);
    wait_done(n);
    chk("b2b2_lat", 64'(n), 64'd65);
    chk("b2b2_hi", bus.hi, 64'd2);
    chk("b2b2_lo", bus.lo, 64'd14);

    // asynchronous reset mid-RUN
    @(posedge clock); #1;
    run_op(MULTU, 64'd5, 64'd5);
    repeat (20) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_hi", bus.hi, 64'd0);
    chk("arst_lo", bus.lo, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    run_op(DIVU, 64'd100, 64'd7);
    wait_done(n);
    chk("post_rst_lat", 64'(n), 64'd65);
    chk("post_rst_lo", bus.lo, 64'd14);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
